// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the mips_cpu_harvard fetch path.
package mips_cpu_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        PC_SEQ,
        PC_SLOT
    } pc_state_t;

    localparam word_t RESET_VECTOR = 32'hBFC0_0000;
    localparam word_t HALT_ADDR    = 32'h0000_0000;

endpackage

// File: rtl/mips_cpu_pc_unit.sv
// Program counter / fetch stage: sequential fetch, one-instruction branch
// delay slot, halt on fetch from HALT_ADDR, sticky misaligned-target error.
module mips_cpu_pc_unit
    import mips_cpu_pkg::*;
#(
    parameter word_t RESET_VECTOR = mips_cpu_pkg::RESET_VECTOR,
    parameter word_t HALT_ADDR    = mips_cpu_pkg::HALT_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] instr_address,
    output logic [31:0] link_address,
    output logic        in_delay_slot,
    output logic        active,
    output logic        fetch_error
);

    pc_state_t state_q, state_d;
    word_t     pc_q, pc_d;
    word_t     saved_q, saved_d;
    logic      active_q, active_d;
    logic      error_q, error_d;
    word_t     pc_plus4;

    // Next-state selection; a halted unit keeps every register unchanged.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        state_d  = state_q;
        pc_d     = pc_q;
        saved_d  = saved_q;
        active_d = active_q;
        error_d  = error_q;
        if (active_q) begin
            case (state_q)
                PC_SEQ: begin
                    pc_d = pc_plus4;
                    if (redirect_valid) begin
                        if (redirect_target[1:0] != 2'b00) begin
                            error_d  = 1'b1;
                            active_d = 1'b0;
                        end else begin
                            saved_d = redirect_target;
                            state_d = PC_SLOT;
                        end
                    end
                end
                PC_SLOT: begin
                    // Branches sitting in a delay slot are ignored.
                    pc_d    = saved_q;
                    state_d = PC_SEQ;
                end
                default: begin
                    state_d = PC_SEQ;
                end
            endcase
            // Reaching the halt address stops the unit on the same edge,
            // dropping any delay slot that would otherwise be entered.
            if (pc_d == HALT_ADDR) begin
                active_d = 1'b0;
                state_d  = PC_SEQ;
            end
        end
    end

    // State, PC and flag registers; reset overrides the global stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PC_SEQ;
            pc_q     <= RESET_VECTOR;
            saved_q  <= '0;
            active_q <= 1'b1;
            error_q  <= 1'b0;
        end else if (clk_enable) begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            saved_q  <= saved_d;
            active_q <= active_d;
            error_q  <= error_d;
        end
    end

    assign instr_address = pc_q;
    assign link_address  = pc_q + 32'd8;
    assign in_delay_slot = (state_q == PC_SLOT);
    assign active        = active_q;
    assign fetch_error   = error_q;

endmodule

// File: tb/tb_mips_cpu_pc_unit.sv
// Bench for mips_cpu_pc_unit: directed vector table, halt-hold sequence,
// and randomized traffic against a fetch-order reference model.
module tb_mips_cpu_pc_unit;

    localparam logic [31:0] B = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_enable = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] instr_address;
    logic [31:0] link_address;
    logic        in_delay_slot;
    logic        active;
    logic        fetch_error;

    int n_total = 0;
    int n_pass  = 0;

    mips_cpu_pc_unit #(
        .RESET_VECTOR(32'hBFC0_0000),
        .HALT_ADDR   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .instr_address  (instr_address),
        .link_address   (link_address),
        .in_delay_slot  (in_delay_slot),
        .active         (active),
        .fetch_error    (fetch_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ce;
        logic        rv;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        slot;
        logic        act;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic ce, input logic rv,
                       input logic [31:0] tgt, input logic [31:0] pc,
                       input logic slot, input logic act, input logic err);
        vec_t v;
        v.rst = rst; v.ce = ce; v.rv = rv; v.tgt = tgt;
        v.pc = pc; v.slot = slot; v.act = act; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", name, got, exp);
        else
            n_pass++;
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc,
                             input logic slot, input logic act, input logic err);
        chk({tag, ".instr_address"}, instr_address, pc);
        chk({tag, ".link_address"}, link_address, pc + 32'd8);
        chk({tag, ".in_delay_slot"}, {31'd0, in_delay_slot}, {31'd0, slot});
        chk({tag, ".active"}, {31'd0, active}, {31'd0, act});
        chk({tag, ".fetch_error"}, {31'd0, fetch_error}, {31'd0, err});
    endtask

    // Drive inputs away from the edge, then sample shortly after it.
    task automatic drive_edge(input logic r, input logic c, input logic v, input logic [31:0] t);
        @(negedge clk);
        reset = r; clk_enable = c; redirect_valid = v; redirect_target = t;
        @(posedge clk);
        #1;
    endtask

    // Reference model: fetch order expressed as a queue of scheduled targets.
    logic [31:0] m_pc;
    logic [31:0] m_sched[$];
    logic        m_act;
    logic        m_err;

    task automatic model_step(input logic r, input logic c, input logic v, input logic [31:0] t);
        logic [31:0] npc;
        if (r) begin
            m_pc = B; m_sched.delete(); m_act = 1'b1; m_err = 1'b0;
        end else if (c && m_act) begin
            if (m_sched.size() != 0) begin
                npc = m_sched.pop_front();
            end else begin
                npc = m_pc + 32'd4;
                if (v && (t % 4 != 0)) begin
                    m_err = 1'b1; m_act = 1'b0;
                end else if (v) begin
                    m_sched.push_back(t);
                end
            end
            if (npc == 32'd0) begin
                m_act = 1'b0;
                m_sched.delete();
            end
            m_pc = npc;
        end
    endtask

    initial begin
        // Directed table: sequential fetch, delay slot, stall, reset, errors, wrap.
        add(1,1,0,0,         B,         0,1,0);
        add(0,1,0,0,         B+4,       0,1,0);
        add(0,1,0,0,         B+8,       0,1,0);
        add(0,1,0,0,         B+12,      0,1,0);
        add(1,1,0,0,         B,         0,1,0);
        add(0,1,0,0,         B+4,       0,1,0);
        add(0,1,1,B+32'h100, B+8,       1,1,0);
        add(0,1,0,0,         B+32'h100, 0,1,0);
        add(0,1,1,B+32'h200, B+32'h104, 1,1,0);
        add(0,0,1,B+32'h300, B+32'h104, 1,1,0);
        add(0,0,1,B+32'h300, B+32'h104, 1,1,0);
        add(0,0,0,0,         B+32'h104, 1,1,0);
        add(0,1,0,0,         B+32'h200, 0,1,0);
        add(0,1,1,B+32'h300, B+32'h204, 1,1,0);
        add(0,1,1,B+32'h400, B+32'h300, 0,1,0);
        add(0,1,1,B+32'h500, B+32'h304, 1,1,0);
        add(1,1,1,B+32'h600, B,         0,1,0);
        add(0,1,0,0,         B+4,       0,1,0);
        add(0,1,1,B+32'h102, B+8,       0,0,1);
        add(0,1,0,0,         B+8,       0,0,1);
        add(0,1,1,B+32'h200, B+8,       0,0,1);
        add(1,0,0,0,         B,         0,1,0);
        add(0,1,1,32'hFFFFFFF8, B+4,    1,1,0);
        add(0,1,0,0,         32'hFFFFFFF8, 0,1,0);
        add(0,1,0,0,         32'hFFFFFFFC, 0,1,0);
        add(0,1,0,0,         32'h0,     0,0,0);
        add(0,1,1,B,         32'h0,     0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive_edge(vecs[i].rst, vecs[i].ce, vecs[i].rv, vecs[i].tgt);
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].slot, vecs[i].act, vecs[i].err);
        end

        // JR to address zero: delay slot, then halt held for ten cycles.
        drive_edge(1, 1, 0, 0);
        drive_edge(0, 1, 0, 0);
        drive_edge(0, 1, 1, 32'h0);
        check_all("jr0.slot", B+8, 1, 1, 0);
        drive_edge(0, 1, 0, 0);
        check_all("jr0.halt", 32'h0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            drive_edge(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), B + 32'h40);
            check_all($sformatf("jr0.hold%0d", k), 32'h0, 0, 0, 0);
        end

        // Randomized traffic against the reference model.
        begin
            logic        r, c, v;
            logic [31:0] t, raw;
            int          idle;
            idle = 0;
            drive_edge(1, 1, 0, 0);
            model_step(1, 1, 0, 0);
            for (int n = 0; n < 2000; n++) begin
                raw = $urandom;
                r = ($urandom_range(0, 59) == 0) || (idle > 4);
                c = ($urandom_range(0, 3) != 0);
                v = ($urandom_range(0, 2) == 0);
                t = B | (raw & 32'h0000_FFFC);
                if ($urandom_range(0, 15) == 0) t = t | 32'h2;
                if ($urandom_range(0, 31) == 0) t = 32'h0;
                drive_edge(r, c, v, t);
                model_step(r, c, v, t);
                check_all($sformatf("rand%0d", n), m_pc, m_sched.size() != 0, m_act, m_err);
                idle = m_act ? 0 : idle + 1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mips_cpu_pc_unit.md
Name: mips_cpu_pc_unit

Overview:
Program-counter / instruction-fetch stage of mips_cpu_harvard, directly upstream of the instruction memory port. It drives instr_address and implements the MIPS branch delay slot. It detects the halt condition (fetch from address 0), which drives the CPU's active output. Decode/execute supplies a single redirect request per cycle; this block turns it into a delayed PC update and provides the link address for JAL/JALR/BGEZAL/BLTZAL.

Parameters:
RESET_VECTOR, 32'hBFC00000, first fetch address after reset
HALT_ADDR, 32'h00000000, fetch address that ends execution

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
clk_enable  input  1  global stall; 0 freezes all state
redirect_valid  input  1  instruction at instr_address is a taken branch/jump
redirect_target  input  32  branch/jump destination (byte address)
instr_address  output  32  current fetch address (registered PC)
link_address  output  32  instr_address+8, combinational, for link writes
in_delay_slot  output  1  current instruction is a delay-slot instruction
active  output  1  1 while CPU is executing; 0 after halt
fetch_error  output  1  sticky; misaligned redirect target seen

Behaviour:
- Reset (posedge clk, reset=1) has priority over clk_enable:
  - instr_address=RESET_VECTOR, active=1, in_delay_slot=0, fetch_error=0.
  - Internal saved_target cleared to 0.
  - Any pending redirect is discarded, including a reset taken mid-delay-slot.
- Update rule: state changes only when clk_enable=1 and active=1. Otherwise every register holds.
- Two-state FSM:
  - SEQ: if redirect_valid=1, then PC<=PC+4, saved_target<=redirect_target, go to SLOT. Else PC<=PC+4.
  - SLOT (in_delay_slot=1): PC<=saved_target, go to SEQ. redirect_valid is ignored in SLOT; a branch in a delay slot is architecturally undefined and has no effect.
- Latency: the redirect takes effect two fetches later. Fetch order is branch, delay slot (PC+4), then target.
- Arithmetic: PC+4 and PC+8 are modulo 2^32. 32'hFFFFFFFC+4 wraps to 0, which triggers a halt.
- Halt:
  - On any edge where the next PC equals HALT_ADDR, PC<=HALT_ADDR and active<=0 together.
  - Once active=0, instr_address stays at HALT_ADDR until reset.
- Misaligned target:
  - If redirect_valid=1 in SEQ with redirect_target[1:0]!=0, then fetch_error<=1 and active<=0 on the same edge.
  - PC<=PC+4 on that edge, and no SLOT entry.
- link_address = instr_address+8 at all times, including after reset.
- Simultaneous reset and redirect: reset wins.
- clk_enable=0 while in SLOT: the block stays in SLOT and saved_target is kept.

Decomposition:
- Package mips_cpu_pkg:
  - RESET_VECTOR and HALT_ADDR constants.
  - typedef enum logic {PC_SEQ, PC_SLOT} pc_state_t.
  - typedef logic[31:0] word_t.
- No sub-module needed. Next-PC selection is one always_comb block, and state/PC/flags are one always_ff block.

Test Plan:
- Reset then 3 cycles with no redirect -> instr_address BFC00000, BFC00004, BFC00008, BFC0000C; active=1; link_address=BFC00014 at the last cycle.
- redirect_valid=1 with target BFC00100 while at BFC00004 -> next fetches BFC00008 (in_delay_slot=1), then BFC00100 (in_delay_slot=0).
- JR-to-zero program (redirect target 0 at BFC00004) -> BFC00008 delay slot, then instr_address=0 and active=0 on the same edge; holds 0 for 10 further cycles.
- Redirect accepted, then clk_enable=0 for 3 cycles in SLOT -> instr_address and in_delay_slot frozen; on re-enable the PC jumps to the saved target.
- reset asserted during SLOT -> next edge instr_address=BFC00000, in_delay_slot=0; the saved target is never fetched.
- redirect target BFC00102 -> fetch_error=1 and active=0 after one edge; instr_address=PC+4 and frozen.
